// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit accumulator with saturating credit, round-robin
// product select, price check, dispenser req/ack handshake with timeout, and
// unit-by-unit change return. All outputs are registered.
module vend_sequencer #(
    parameter int CW      = 3,
    parameter int PRICE0  = 2,
    parameter int PRICE1  = 3,
    parameter int PRICE2  = 4,
    parameter int PRICE3  = 5,
    parameter int IDLE_TO = 200,
    parameter int ACK_TO  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          coin,
    input  logic          cancel,
    input  logic [3:0]    sel_req,
    input  logic          disp_ack,
    output logic          disp_req,
    output logic [1:0]    disp_prod,
    output logic [3:0]    grant,
    output logic [CW-1:0] credit,
    output logic          refund_pulse,
    output logic          coin_reject,
    output logic          err_insuf,
    output logic          fault,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ARB,
        S_VEND,
        S_REFUND
    } state_t;

    localparam int IW = $clog2(IDLE_TO + 1);
    localparam int AW = $clog2(ACK_TO + 1);
    localparam logic [CW-1:0] CMAX = '1;

    state_t        state;
    logic [3:0]    sel_lat;
    logic [1:0]    ptr;
    logic [IW-1:0] idle_cnt;
    logic [AW-1:0] ack_cnt;
    logic [CW-1:0] price_lat;

    logic [1:0]    pick;
    logic [1:0]    idx;
    logic          found;
    logic [CW-1:0] price_pick;

    // Round-robin pick: first latched request after the pointer, pointer itself last.
    always_comb begin
        pick  = ptr;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && sel_lat[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Price lookup for the picked product.
    always_comb begin
        price_pick = CW'(PRICE0);
        case (pick)
            2'd1:    price_pick = CW'(PRICE1);
            2'd2:    price_pick = CW'(PRICE2);
            2'd3:    price_pick = CW'(PRICE3);
            default: price_pick = CW'(PRICE0);
        endcase
    end

    // Sequencer FSM with registered outputs; ena=0 freezes everything but clears pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            credit       <= '0;
            sel_lat      <= '0;
            ptr          <= 2'd3;
            idle_cnt     <= '0;
            ack_cnt      <= '0;
            price_lat    <= '0;
            disp_req     <= 1'b0;
            disp_prod    <= '0;
            grant        <= '0;
            refund_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            err_insuf    <= 1'b0;
            fault        <= 1'b0;
            busy         <= 1'b0;
        end else if (!ena) begin
            refund_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            err_insuf    <= 1'b0;
            fault        <= 1'b0;
        end else begin
            refund_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            err_insuf    <= 1'b0;
            fault        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (coin) begin
                        credit   <= CW'(1);
                        idle_cnt <= '0;
                        state    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (coin) begin
                        if (credit != CMAX) credit <= credit + 1'b1;
                        else                coin_reject <= 1'b1;
                    end
                    if (cancel) begin
                        state <= S_REFUND;
                        busy  <= 1'b1;
                    end else if (sel_req != '0) begin
                        sel_lat  <= sel_req;
                        idle_cnt <= '0;
                        state    <= S_ARB;
                        busy     <= 1'b1;
                    end else if (coin) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IW'(IDLE_TO - 1)) begin
                        state <= S_REFUND;
                        busy  <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_ARB: begin
                    if (coin) coin_reject <= 1'b1;
                    ptr <= pick;
                    if (credit >= price_pick) begin
                        credit    <= credit - price_pick;
                        price_lat <= price_pick;
                        grant     <= 4'b0001 << pick;
                        disp_prod <= pick;
                        disp_req  <= 1'b1;
                        ack_cnt   <= '0;
                        state     <= S_VEND;
                    end else begin
                        err_insuf <= 1'b1;
                        idle_cnt  <= '0;
                        state     <= S_COLLECT;
                        busy      <= 1'b0;
                    end
                end
                S_VEND: begin
                    if (coin) coin_reject <= 1'b1;
                    if (disp_ack) begin
                        disp_req  <= 1'b0;
                        grant     <= '0;
                        disp_prod <= '0;
                        if (credit != '0) begin
                            state <= S_REFUND;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (ack_cnt == AW'(ACK_TO - 1)) begin
                        // Dispenser never answered: give the price back and let the user retry.
                        fault     <= 1'b1;
                        credit    <= credit + price_lat;
                        disp_req  <= 1'b0;
                        grant     <= '0;
                        disp_prod <= '0;
                        idle_cnt  <= '0;
                        state     <= S_COLLECT;
                        busy      <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_REFUND: begin
                    if (coin) coin_reject <= 1'b1;
                    if (credit != '0) begin
                        refund_pulse <= 1'b1;
                        credit       <= credit - 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed testbench for vend_sequencer: inputs change after the falling edge,
// outputs are checked at the falling edge against hand-computed values.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       coin;
    logic       cancel;
    logic [3:0] sel_req;
    logic       disp_ack;
    logic       disp_req;
    logic [1:0] disp_prod;
    logic [3:0] grant;
    logic [2:0] credit;
    logic       refund_pulse;
    logic       coin_reject;
    logic       err_insuf;
    logic       fault;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int r;

    vend_sequencer #(
        .CW(3), .PRICE0(2), .PRICE1(3), .PRICE2(4), .PRICE3(5),
        .IDLE_TO(200), .ACK_TO(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .coin(coin), .cancel(cancel),
        .sel_req(sel_req), .disp_ack(disp_ack), .disp_req(disp_req),
        .disp_prod(disp_prod), .grant(grant), .credit(credit),
        .refund_pulse(refund_pulse), .coin_reject(coin_reject),
        .err_insuf(err_insuf), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) begin
            coin = 1'b1;
            tick();
        end
        coin = 1'b0;
    endtask

    task automatic count_refunds(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            cnt += int'(refund_pulse);
        end
    endtask

    task automatic select(input logic [3:0] s);
        sel_req = s;
        tick();
        sel_req = '0;
    endtask

    task automatic ack();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; coin = 1'b0; cancel = 1'b0;
        sel_req = '0; disp_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_disp_req", disp_req, 0);
        check("rst_grant", grant, 0);

        // exact buy
        coins(2);
        check("t2_credit", credit, 2);
        select(4'b0001);
        check("t2_busy_arb", busy, 1);
        tick();
        check("t2_grant", grant, 4'b0001);
        check("t2_disp_req", disp_req, 1);
        check("t2_prod", disp_prod, 0);
        check("t2_credit_vend", credit, 0);
        ack();
        check("t2_req_drop", disp_req, 0);
        check("t2_idle", busy, 0);
        count_refunds(5, r);
        check("t2_refunds", r, 0);

        // change return
        coins(7);
        check("t3_credit", credit, 7);
        select(4'b0100);
        tick();
        check("t3_grant", grant, 4'b0100);
        check("t3_prod", disp_prod, 2);
        check("t3_credit_vend", credit, 3);
        ack();
        check("t3_req_drop", disp_req, 0);
        check("t3_busy_refund", busy, 1);
        count_refunds(6, r);
        check("t3_refunds", r, 3);
        check("t3_credit_end", credit, 0);
        check("t3_idle", busy, 0);

        // saturation, cancel refund, insufficient credit
        coins(7);
        coin = 1'b1; tick(); coin = 1'b0;
        check("t4_reject", coin_reject, 1);
        check("t4_sat", credit, 7);
        tick();
        check("t4_reject_pulse", coin_reject, 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        count_refunds(10, r);
        check("t4_cancel_refunds", r, 7);
        coins(1);
        select(4'b0010);
        tick();
        check("t4_insuf", err_insuf, 1);
        check("t4_insuf_credit", credit, 1);
        check("t4_collect", busy, 0);
        check("t4_no_req", disp_req, 0);
        tick();
        check("t4_insuf_pulse", err_insuf, 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        count_refunds(4, r);
        check("t4_refund1", r, 1);

        // round robin from a fresh pointer
        do_reset();
        coins(7);
        select(4'b1111);
        tick();
        check("t5_grant0", grant, 4'b0001);
        check("t5_prod0", disp_prod, 0);
        check("t5_credit0", credit, 5);
        ack();
        count_refunds(8, r);
        check("t5_refunds", r, 5);
        check("t5_idle", busy, 0);
        coins(7);
        select(4'b1111);
        tick();
        check("t5_grant1", grant, 4'b0010);
        check("t5_prod1", disp_prod, 1);
        check("t5_credit1", credit, 4);

        // ack timeout
        repeat (14) tick();
        check("t6_req_held", disp_req, 1);
        check("t6_no_fault_yet", fault, 0);
        tick();
        check("t6_fault", fault, 1);
        check("t6_req_drop", disp_req, 0);
        check("t6_restored", credit, 7);
        check("t6_grant_clr", grant, 0);
        check("t6_collect", busy, 0);
        tick();
        check("t6_fault_pulse", fault, 0);

        // idle timeout
        repeat (198) tick();
        check("t6_idle_wait", busy, 0);
        check("t6_idle_credit", credit, 7);
        tick();
        check("t6_idle_to", busy, 1);
        count_refunds(10, r);
        check("t6_idle_refunds", r, 7);
        check("t6_idle_credit_end", credit, 0);

        // coin and select in the same cycle
        coins(1);
        coin = 1'b1; sel_req = 4'b0001;
        tick();
        coin = 1'b0; sel_req = '0;
        check("t6_same_credit", credit, 2);
        tick();
        check("t6_same_grant", grant, 4'b0001);
        check("t6_same_no_insuf", err_insuf, 0);
        check("t6_same_credit_vend", credit, 0);

        // reset in the middle of a vend
        #2 rst_n = 1'b0;
        #1;
        check("t1_req", disp_req, 0);
        check("t1_credit", credit, 0);
        check("t1_busy", busy, 0);
        check("t1_grant", grant, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // enable freeze during vend
        coins(2);
        select(4'b0001);
        tick();
        check("en_vend", disp_req, 1);
        ena = 1'b0; coin = 1'b1;
        repeat (20) tick();
        check("en_req_frozen", disp_req, 1);
        check("en_no_fault", fault, 0);
        check("en_no_reject", coin_reject, 0);
        check("en_credit", credit, 0);
        coin = 1'b0; ena = 1'b1;
        tick();
        check("en_resume", disp_req, 1);
        check("en_resume_fault", fault, 0);
        ack();
        check("en_done_req", disp_req, 0);
        check("en_done_idle", busy, 0);
        ack();
        check("ack_idle_ignored", busy, 0);
        check("ack_idle_credit", credit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
